// File: rtl/definitions.sv
// Shared pipeline definitions: stall encoding, instruction width and the
// fetch queue entry layout.
package definitions;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam int INSTR_W = 32;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory bus between the fetch stage (master) and memory (slave):
// valid/ready request channel, in-order response channel without backpressure.
interface fetch_unit_if
  import definitions::*;
;
  logic               imem_req_valid;
  logic [31:0]        imem_req_addr;
  logic               imem_req_ready;
  logic               imem_resp_valid;
  logic [INSTR_W-1:0] imem_resp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid,
    input  imem_resp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid,
    output imem_resp_data
  );

endinterface

// File: rtl/fetch_queue.sv
// Parameterised circular FIFO with push, pop, flush and occupancy count.
// Push into a full queue is accepted only when a pop frees a slot that cycle.
module fetch_queue #(
  parameter int  DEPTH = 2,
  parameter type T     = logic [31:0]
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  T                       push_data,
  input  logic                   pop,
  output T                       head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int             PTR_W   = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  T                 mem_q [DEPTH];
  T                 mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != DEPTH_C) || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (PTR_W+1)'(1);
        2'b01:   count_d = count_q - (PTR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is data only and carries no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    head  = mem_q[rd_ptr_q];
    count = count_q;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues credit-limited in-order memory
// requests, buffers tagged responses and presents the queue head to decode.
module fetch_unit
  import definitions::*;
#(
  parameter int          QDEPTH   = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stallIF,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  fetch_unit_if.master       imem,
  output logic               D_valid,
  output logic [INSTR_W-1:0] D_instr,
  output logic [31:0]        D_pc,
  output logic [31:0]        D_pc4
);

  localparam int             CNT_W    = $clog2(QDEPTH) + 1;
  localparam logic [CNT_W:0] QDEPTH_C = (CNT_W+1)'(QDEPTH);

  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [CNT_W-1:0] iq_count;
  logic [CNT_W-1:0] outstanding;
  fetch_entry_t     iq_head;
  fetch_entry_t     iq_push_data;
  logic [31:0]      af_head;
  logic             req_fire;
  logic             resp_ok;
  logic             resp_keep;
  logic             iq_pop;

  // Credit counts dropped requests too, so every response finds queue space.
  always_comb begin
    imem.imem_req_valid = !reset && !redirect &&
                          (({1'b0, iq_count} + {1'b0, outstanding}) < QDEPTH_C);
    imem.imem_req_addr  = pc_q;
    req_fire            = imem.imem_req_valid && imem.imem_req_ready;
    resp_ok             = imem.imem_resp_valid && (outstanding != '0);
    resp_keep           = resp_ok && (drop_q == '0) && !redirect;
    iq_pop              = D_valid && (stallIF == DISABLE) && !redirect;
    iq_push_data        = '{instr: imem.imem_resp_data, pc: af_head};
  end

  always_comb begin
    pc_d   = pc_q;
    drop_d = drop_q;
    if (resp_ok && (drop_q != '0)) begin
      drop_d = drop_q - CNT_W'(1);
    end
    if (redirect) begin
      pc_d   = {redirect_pc[31:2], 2'b00};
      drop_d = outstanding - CNT_W'(resp_ok);
    end else if (req_fire) begin
      pc_d = pc_plus4(pc_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q   <= RESET_PC;
      drop_q <= '0;
    end else begin
      pc_q   <= pc_d;
      drop_q <= drop_d;
    end
  end

  // Request addresses in flight; occupancy doubles as the outstanding count.
  fetch_queue #(
    .DEPTH (QDEPTH),
    .T     (logic [31:0])
  ) u_af (
    .clk       (clk),
    .reset     (reset),
    .flush     (1'b0),
    .push      (req_fire),
    .push_data (imem.imem_req_addr),
    .pop       (resp_ok),
    .head      (af_head),
    .count     (outstanding)
  );

  fetch_queue #(
    .DEPTH (QDEPTH),
    .T     (fetch_entry_t)
  ) u_iq (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect),
    .push      (resp_keep),
    .push_data (iq_push_data),
    .pop       (iq_pop),
    .head      (iq_head),
    .count     (iq_count)
  );

  // Decode outputs come from queue-head registers only, zeroed when empty.
  always_comb begin
    D_valid = (iq_count != '0);
    D_instr = D_valid ? iq_head.instr : '0;
    D_pc    = D_valid ? iq_head.pc : '0;
    D_pc4   = D_valid ? pc_plus4(iq_head.pc) : '0;
  end

  always @(posedge clk) begin
    if (!reset) begin
      assert (!(imem.imem_resp_valid && (outstanding == '0)));
      assert (!(redirect && (redirect_pc[1:0] != 2'b00)));
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a fixed-latency in-order memory model.
module tb_fetch_unit;

  typedef struct {
    int          due;
    logic [31:0] addr;
  } mem_req_t;

  logic        clk;
  logic        reset;
  logic        stallIF;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        D_valid;
  logic [31:0] D_instr;
  logic [31:0] D_pc;
  logic [31:0] D_pc4;

  fetch_unit_if imem ();

  fetch_unit #(
    .QDEPTH   (4),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .stallIF     (stallIF),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (imem),
    .D_valid     (D_valid),
    .D_instr     (D_instr),
    .D_pc        (D_pc),
    .D_pc4       (D_pc4)
  );

  int          n_chk = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  int          mem_k = 1;
  mem_req_t    pend[$];
  logic [31:0] popq[$];
  logic [31:0] reqlog[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // One clock: drive the due response, log request fire and decode pop, advance.
  task automatic tick();
    mem_req_t m;
    imem.imem_resp_valid = 1'b0;
    imem.imem_resp_data  = '0;
    if (pend.size() != 0 && pend[0].due == cyc) begin
      m = pend.pop_front();
      imem.imem_resp_valid = 1'b1;
      imem.imem_resp_data  = instr_of(m.addr);
    end
    #1;
    if (imem.imem_req_valid === 1'b1 && imem.imem_req_ready === 1'b1) begin
      m.due  = cyc + mem_k;
      m.addr = imem.imem_req_addr;
      pend.push_back(m);
      reqlog.push_back(m.addr);
    end
    if (D_valid === 1'b1 && !stallIF && !redirect && !reset) begin
      chk("pop_instr", D_instr, instr_of(D_pc));
      popq.push_back(D_pc);
    end
    @(posedge clk);
    cyc++;
    if (reset) pend.delete();
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    stallIF  = 1'b0;
    redirect = 1'b0;
    imem.imem_req_ready = 1'b1;
    tick();
    tick();
    popq.delete();
    reqlog.delete();
    reset = 1'b0;
    #1;
  endtask

  task automatic check_seq(input string tag, input logic [31:0] q[$],
                           input logic [31:0] start, input int min_len);
    chk({tag, "_len"}, 32'(q.size() >= min_len), 32'd1);
    foreach (q[i]) chk(tag, q[i], start + 32'(i) * 32'd4);
  endtask

  initial begin
    reset       = 1'b1;
    stallIF     = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    imem.imem_req_ready  = 1'b1;
    imem.imem_resp_valid = 1'b0;
    imem.imem_resp_data  = '0;

    // Reset state
    tick();
    tick();
    chk("rst_dvalid", 32'(D_valid), 32'd0);
    chk("rst_dinstr", D_instr, 32'd0);
    chk("rst_dpc",    D_pc,    32'd0);
    chk("rst_dpc4",   D_pc4,   32'd0);
    chk("rst_reqv",   32'(imem.imem_req_valid), 32'd0);
    chk("rst_count",  32'(dut.u_iq.count), 32'd0);
    popq.delete();
    reqlog.delete();
    reset = 1'b0;
    #1;

    // Streaming, k = 1
    chk("first_reqv", 32'(imem.imem_req_valid), 32'd1);
    chk("first_addr", imem.imem_req_addr, 32'h0);
    tick();
    chk("c1_dvalid", 32'(D_valid), 32'd0);
    chk("c1_addr",   imem.imem_req_addr, 32'h4);
    tick();
    chk("c2_dvalid", 32'(D_valid), 32'd1);
    chk("c2_dpc",    D_pc, 32'h0);
    chk("c2_dinstr", D_instr, instr_of(32'h0));
    chk("c2_dpc4",   D_pc4, 32'h4);
    chk("c2_addr",   imem.imem_req_addr, 32'h8);
    tick();
    chk("c3_dpc", D_pc, 32'h4);
    tick();
    chk("c4_dpc", D_pc, 32'h8);

    // Stall until the queue is full, hold three cycles, release
    stallIF = 1'b1;
    tick();
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("stall_dpc",   D_pc, 32'h8);
      chk("stall_instr", D_instr, instr_of(32'h8));
      chk("stall_reqv",  32'(imem.imem_req_valid), 32'd0);
      chk("stall_count", 32'(dut.u_iq.count), 32'd4);
      if (i != 2) tick();
    end
    stallIF = 1'b0;
    tick();
    chk("rel_dpc0", D_pc, 32'hC);
    tick();
    chk("rel_dpc1", D_pc, 32'h10);
    for (int i = 0; i < 6; i++) tick();
    check_seq("seq_stream", popq, 32'h0, 8);

    // Redirect with two requests outstanding, k = 3
    mem_k = 3;
    do_reset();
    tick();
    tick();
    chk("k3_outstanding", 32'(dut.outstanding), 32'd2);
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    #1;
    chk("k3_redir_reqv", 32'(imem.imem_req_valid), 32'd0);
    tick();
    redirect = 1'b0;
    #1;
    chk("k3_post_dvalid", 32'(D_valid), 32'd0);
    chk("k3_post_reqv",   32'(imem.imem_req_valid), 32'd1);
    chk("k3_post_addr",   imem.imem_req_addr, 32'h100);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("k3_drop_dvalid", 32'(D_valid), 32'd0);
    end
    tick();
    chk("k3_first_dvalid", 32'(D_valid), 32'd1);
    chk("k3_first_dpc",    D_pc, 32'h100);
    chk("k3_first_instr",  D_instr, instr_of(32'h100));
    for (int i = 0; i < 10; i++) tick();
    check_seq("seq_k3", popq, 32'h100, 5);

    // Redirect together with stall on a full queue, k = 1
    mem_k = 1;
    do_reset();
    stallIF = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("rs_full_count", 32'(dut.u_iq.count), 32'd4);
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    #1;
    chk("rs_redir_reqv", 32'(imem.imem_req_valid), 32'd0);
    tick();
    redirect = 1'b0;
    stallIF  = 1'b0;
    #1;
    chk("rs_dvalid", 32'(D_valid), 32'd0);
    chk("rs_count",  32'(dut.u_iq.count), 32'd0);
    chk("rs_reqv",   32'(imem.imem_req_valid), 32'd1);
    chk("rs_addr",   imem.imem_req_addr, 32'h100);
    tick();
    chk("rs_c7_dvalid", 32'(D_valid), 32'd0);
    tick();
    chk("rs_c8_dpc", D_pc, 32'h100);

    // Toggling ready
    do_reset();
    tick();
    imem.imem_req_ready = 1'b0;
    #1;
    chk("tog_reqv",  32'(imem.imem_req_valid), 32'd1);
    chk("tog_addr1", imem.imem_req_addr, 32'h4);
    tick();
    imem.imem_req_ready = 1'b1;
    #1;
    chk("tog_addr2", imem.imem_req_addr, 32'h4);
    tick();
    for (int i = 0; i < 20; i++) begin
      imem.imem_req_ready = (i % 2 == 1);
      tick();
    end
    check_seq("seq_tog_pop", popq, 32'h0, 6);
    check_seq("seq_tog_req", reqlog, 32'h0, 8);

    // Redirect to the top of the address space: pc + 4 wraps
    imem.imem_req_ready = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    tick();
    tick();
    chk("wrap_dvalid", 32'(D_valid), 32'd1);
    chk("wrap_dpc",    D_pc, 32'hFFFF_FFFC);
    chk("wrap_dpc4",   D_pc4, 32'h0);
    tick();
    chk("wrap_next_dpc", D_pc, 32'h0);

    // Reset with two entries queued
    do_reset();
    stallIF = 1'b1;
    tick();
    tick();
    tick();
    chk("mid_dvalid", 32'(D_valid), 32'd1);
    chk("mid_count",  32'(dut.u_iq.count), 32'd2);
    reset = 1'b1;
    tick();
    chk("mid_rst_dvalid", 32'(D_valid), 32'd0);
    chk("mid_rst_reqv",   32'(imem.imem_req_valid), 32'd0);
    reset   = 1'b0;
    stallIF = 1'b0;
    #1;
    chk("mid_first_reqv", 32'(imem.imem_req_valid), 32'd1);
    chk("mid_first_addr", imem.imem_req_addr, 32'h0);
    tick();
    tick();
    chk("mid_first_dpc", D_pc, 32'h0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
